// File: rtl/multdiv_unit_pkg.sv
// rtl/multdiv_unit_pkg.sv - shared op codes, FSM states and operand helpers for the HI/LO unit
//
// multicycle_t : 4-bit op code driven by execute (values 8..15 are not defined and run as M_MULTU)
// mdstate_t    : MD_IDLE -> MD_BUSY -> MD_DONE
package multdiv_unit_pkg;

  typedef enum logic [3:0] {
    M_MULT  = 4'd0,
    M_MULTU = 4'd1,
    M_DIV   = 4'd2,
    M_DIVU  = 4'd3,
    M_MADD  = 4'd4,
    M_MADDU = 4'd5,
    M_MSUB  = 4'd6,
    M_MSUBU = 4'd7
  } multicycle_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } mdstate_t;

  localparam int DATA_W = 32;

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == M_DIV) || (op == M_DIVU);
  endfunction

  // Only the four two's-complement ops; everything else (including undefined codes) is unsigned.
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == M_MULT) || (op == M_MADD) || (op == M_MSUB) || (op == M_DIV);
  endfunction

  // Magnitude of x when it is to be read as signed; 0x8000_0000 maps to itself, which is correct as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - request/response bundle between execute (master) and the HI/LO unit (slave)
//
// a, b            : operands, sampled only at accept
// is_multdiv      : request valid, held by execute until ok
// multicycle_type : op code (multicycle_t encoding)
// flushE          : abort the op in flight, discard its result
// hi, lo          : registered result
// ok              : one-cycle result-valid pulse
interface multdiv_if;
  import multdiv_unit_pkg::*;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              is_multdiv;
  logic [3:0]        multicycle_type;
  logic              flushE;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              ok;

  modport master (
    output a, b, is_multdiv, multicycle_type, flushE,
    input  hi, lo, ok
  );

  modport slave (
    input  a, b, is_multdiv, multicycle_type, flushE,
    output hi, lo, ok
  );

endinterface

// File: rtl/multdiv_unit_div_radix2.sv
// rtl/multdiv_unit_div_radix2.sv - restoring unsigned 32/32 divider, one quotient bit per cycle
//
// clk, resetn          : clock, synchronous active-low reset
// start                : load operands; the first quotient bit is produced on this same edge
// flush                : abandon the division in flight
// dividend, divisor    : unsigned operands, sampled only with start
// quotient, remainder  : results, valid while done is high
// done                 : high from the cycle after the last iteration until the next start/flush
module div_radix2
  import multdiv_unit_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [5:0]        cnt_q;
  logic              busy_q;

  logic [DATA_W-1:0] rem_in, quo_in, dvs_in, rem_nx, quo_nx;
  logic [DATA_W:0]   trial, diff;

  // The step works from the raw inputs on the start edge so the load costs no extra cycle.
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    dvs_in = start ? divisor : dvs_q;
    trial  = {rem_in, quo_in[DATA_W-1]};
    diff   = trial - {1'b0, dvs_in};
    // diff[DATA_W] is the borrow: set means the trial remainder is smaller than the divisor.
    rem_nx = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_nx = {quo_in[DATA_W-2:0], ~diff[DATA_W]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (flush) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      dvs_q  <= divisor;
      cnt_q  <= 6'd1;
      busy_q <= 1'b1;
    end else if (busy_q && (cnt_q != 6'(ITERS))) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = busy_q && (cnt_q == 6'(ITERS));

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multi-cycle HI/LO multiply/divide responder for the execute stage
//
// clk    : clock
// resetn : synchronous active-low reset (also clears hi/lo)
// bus    : multdiv_if.slave - a, b, is_multdiv, multicycle_type, flushE in; hi, lo, ok out
// Multiply ops report ok MULT_LATENCY cycles after accept, DIV/DIVU DIV_ITERS+1 cycles after.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int MULT_LATENCY = 3,
  parameter int DIV_ITERS    = 32
) (
  input  logic     clk,
  input  logic     resetn,
  multdiv_if.slave bus
);

  localparam int MULT_LAST = (MULT_LATENCY >= 2) ? MULT_LATENCY - 2 : 0;

  mdstate_t          state;
  logic [5:0]        counter;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              ok_q;

  // Latched request
  logic              op_div, a_neg, b_neg, b_zero;
  logic [DATA_W-1:0] a_save;
  logic signed [DATA_W:0] op_a, op_b;

  logic              in_div, in_sgn, div_start, div_done;
  logic signed [DATA_W:0] in_a33, in_b33, mul_a, mul_b;
  logic signed [2*DATA_W-1:0] product;
  logic [2*DATA_W-1:0] mult_result;
  logic [DATA_W-1:0] div_q, div_r, quo_fix, rem_fix;

  assign in_div    = op_is_div(bus.multicycle_type);
  assign in_sgn    = op_is_signed(bus.multicycle_type);
  assign in_a33    = {in_sgn & bus.a[DATA_W-1], bus.a};
  assign in_b33    = {in_sgn & bus.b[DATA_W-1], bus.b};
  assign div_start = (state == MD_IDLE) && bus.is_multdiv && !bus.flushE && in_div;

  // 33x33 signed multiply covers both signednesses; the low 64 bits are the wanted product.
  assign mul_a   = (MULT_LATENCY == 1) ? in_a33 : op_a;
  assign mul_b   = (MULT_LATENCY == 1) ? in_b33 : op_b;
  assign product = mul_a * mul_b;

  // Operands are held steady in op_a/op_b during BUSY, so the stages need no valid bits.
  if (MULT_LATENCY >= 3) begin : g_mul_pipe
    localparam int DEPTH = MULT_LATENCY - 2;
    logic [2*DATA_W-1:0] pipe [DEPTH];
    always_ff @(posedge clk) begin
      pipe[0] <= product;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
    assign mult_result = pipe[DEPTH-1];
  end else begin : g_mul_direct
    assign mult_result = product;
  end

  div_radix2 #(.ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .flush     (bus.flushE),
    .dividend  (magnitude(bus.a, in_sgn)),
    .divisor   (magnitude(bus.b, in_sgn)),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  // Sign fix-up happens in the cycle after the last iteration; divide-by-zero overrides it.
  assign quo_fix = b_zero ? '1 : ((a_neg ^ b_neg) ? (~div_q + 1'b1) : div_q);
  assign rem_fix = b_zero ? a_save : (a_neg ? (~div_r + 1'b1) : div_r);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= MD_IDLE;
      counter <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ok_q    <= 1'b0;
      op_div  <= 1'b0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      b_zero  <= 1'b0;
      a_save  <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else if (bus.flushE) begin
      state   <= MD_IDLE;
      counter <= '0;
      ok_q    <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          ok_q <= 1'b0;
          if (bus.is_multdiv) begin
            op_div  <= in_div;
            a_neg   <= in_sgn & bus.a[DATA_W-1];
            b_neg   <= in_sgn & bus.b[DATA_W-1];
            b_zero  <= (bus.b == '0);
            a_save  <= bus.a;
            op_a    <= in_a33;
            op_b    <= in_b33;
            counter <= '0;
            if (!in_div && (MULT_LATENCY == 1)) begin
              state        <= MD_DONE;
              ok_q         <= 1'b1;
              {hi_q, lo_q} <= product;
            end else begin
              state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          counter <= counter + 6'd1;
          if (op_div ? div_done : (counter == 6'(MULT_LAST))) begin
            state        <= MD_DONE;
            ok_q         <= 1'b1;
            {hi_q, lo_q} <= op_div ? {rem_fix, quo_fix} : mult_result;
          end
        end
        MD_DONE: begin
          ok_q  <= 1'b0;
          state <= MD_IDLE;
        end
        default: begin
          ok_q  <= 1'b0;
          state <= MD_IDLE;
        end
      endcase
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.ok = ok_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - self-checking bench for multdiv_unit
module tb_multdiv_unit;
  import multdiv_unit_pkg::*;

  localparam int MULT_LAT = 3;
  localparam int DIV_LAT  = 33;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ok_count = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [63:0] last_res = '0;

  multdiv_if bus();

  multdiv_unit #(.MULT_LATENCY(MULT_LAT), .DIV_ITERS(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_;
    longint p;
    sa  = a;
    sb_ = b;
    case (op)
      M_MULT, M_MADD, M_MSUB: begin
        p = longint'(sa) * longint'(sb_);
        return p;
      end
      M_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb_), 32'(sa / sb_)};
      end
      M_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {32'h0, a} * {32'h0, b};
    endcase
  endfunction

  // Scoreboard consumer: every ok pulse must match the oldest outstanding request, on its due cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.ok === 1'b1) begin
      sb_entry_t e;
      ok_count++;
      if (sb.size() == 0) begin
        check("spurious_ok", {63'b0, bus.ok}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("hi", {32'h0, bus.hi}, {32'h0, e.res[63:32]});
        check("lo", {32'h0, bus.lo}, {32'h0, e.res[31:0]});
        check("ok_cycle", 64'(cyc), 64'(e.due));
        last_res = e.res;
      end
    end
  end

  // Drive a request now (caller is at a negedge); accept_delay counts idle cycles before acceptance.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int accept_delay);
    sb_entry_t e;
    bus.multicycle_type = op;
    bus.a               = a;
    bus.b               = b;
    bus.is_multdiv      = 1'b1;
    e.res = exp;
    e.due = cyc + accept_delay + (((op == M_DIV) || (op == M_DIVU)) ? DIV_LAT : MULT_LAT);
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    bus.is_multdiv = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    @(negedge clk);
    start_op(op, a, b, exp, 0);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [63:0] prev;
  int          n0;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    resetn              = 1'b0;
    bus.is_multdiv      = 1'b0;
    bus.flushE          = 1'b0;
    bus.a               = '0;
    bus.b               = '0;
    bus.multicycle_type = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", {32'h0, bus.hi}, 64'd0);
    check("rst_lo", {32'h0, bus.lo}, 64'd0);
    check("rst_ok", {63'h0, bus.ok}, 64'd0);
    resetn = 1'b1;

    // Directed results
    do_op(M_MULT,  32'hFFFF_FFFE, 32'd3,         {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(M_MULTU, 32'hFFFF_FFFE, 32'd3,         {32'h0000_0002, 32'hFFFF_FFFA});
    do_op(M_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(M_DIVU,  32'd7,         32'd2,         {32'h0000_0001, 32'h0000_0003});
    do_op(M_DIVU,  32'h0000_1234, 32'd0,         {32'h0000_1234, 32'hFFFF_FFFF});
    do_op(M_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    do_op(M_DIV,   32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    do_op(M_MADD,  32'd7,         32'hFFFF_FFFB, {32'hFFFF_FFFF, 32'hFFFF_FFDD});
    do_op(M_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    do_op(4'hC,    32'hFFFF_FFFF, 32'd2,         {32'h0000_0001, 32'hFFFF_FFFE});

    // Flush a DIV ten cycles in; next-cycle MULT must still complete normally
    @(negedge clk);
    prev = last_res;
    n0   = ok_count;
    start_op(M_DIV, 32'd1000, 32'd7, ref_model(M_DIV, 32'd1000, 32'd7), 0);
    repeat (10) @(negedge clk);
    bus.flushE = 1'b1;
    sb.delete();
    @(negedge clk);
    bus.flushE = 1'b0;
    check("flush_hi", {32'h0, bus.hi}, {32'h0, prev[63:32]});
    check("flush_lo", {32'h0, bus.lo}, {32'h0, prev[31:0]});
    check("flush_no_ok", 64'(ok_count - n0), 64'd0);
    start_op(M_MULT, 32'hFFFF_0001, 32'h0001_0000, ref_model(M_MULT, 32'hFFFF_0001, 32'h0001_0000), 0);
    wait_drain();

    // Flush in the same cycle as a would-be accept
    @(negedge clk);
    n0   = ok_count;
    prev = last_res;
    bus.multicycle_type = M_MULT;
    bus.a = 32'd3;
    bus.b = 32'd4;
    bus.is_multdiv = 1'b1;
    bus.flushE     = 1'b1;
    @(negedge clk);
    bus.is_multdiv = 1'b0;
    bus.flushE     = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_accept_no_ok", 64'(ok_count - n0), 64'd0);
    check("flush_accept_lo", {32'h0, bus.lo}, {32'h0, prev[31:0]});

    // Back-to-back MULT then DIVU with is_multdiv held; operands scrambled while busy
    @(negedge clk);
    n0 = ok_count;
    start_op(M_MULT, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(M_MULT, 32'h1234_5678, 32'h9ABC_DEF0), 0);
    @(negedge clk);
    bus.a = $urandom;
    bus.b = $urandom;
    repeat (2) @(negedge clk);
    start_op(M_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, ref_model(M_DIVU, 32'hDEAD_BEEF, 32'h0000_1234), 1);
    repeat (2) @(negedge clk);
    bus.a = $urandom;
    bus.b = $urandom;
    bus.multicycle_type = M_MULT;
    wait_drain();
    repeat (3) @(negedge clk);
    check("b2b_ok_pulses", 64'(ok_count - n0), 64'd2);

    // Reset pulse in the middle of a MULT
    @(negedge clk);
    start_op(M_MULT, 32'h0000_0100, 32'h0000_0200, ref_model(M_MULT, 32'h0000_0100, 32'h0000_0200), 0);
    n0 = ok_count;
    @(negedge clk);
    resetn = 1'b0;
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    bus.is_multdiv = 1'b0;
    last_res = '0;
    check("rst_mid_hi", {32'h0, bus.hi}, 64'd0);
    check("rst_mid_lo", {32'h0, bus.lo}, 64'd0);
    check("rst_mid_ok", {63'h0, bus.ok}, 64'd0);
    repeat (5) @(negedge clk);
    check("rst_mid_no_ok", 64'(ok_count - n0), 64'd0);

    // Random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      do_op(r_op, r_a, r_b, ref_model(r_op, r_a, r_b));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
